// File: rtl/hazard_scoreboard_if.sv
// Purpose: ID-stage request and hazard-control response bundle for hazard_scoreboard.
// Latency: plain wires; timing belongs to whichever module drives each side.
// Backpressure: the response carries stall (hold IF/ID) and the request carries freeze (hold everything).
`timescale 1ns/1ps
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 16,
    parameter int DEPTH    = 3,
    parameter int NUM_SRC  = 2
);
    localparam int AW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SELW = $clog2(DEPTH + 1);

    // pipeline control from the core
    logic                    freeze;
    logic                    flush;
    // instruction currently in ID
    logic                    id_valid;
    logic [NUM_SRC*AW-1:0]   id_src_reg;
    logic [NUM_SRC-1:0]      id_src_en;
    logic [AW-1:0]           id_dst_reg;
    logic                    id_dst_en;
    logic                    id_is_load;
    // hazard decisions back to the core
    logic [NUM_SRC*SELW-1:0] fwd_sel;
    logic                    stall;
    logic [DEPTH-1:0]        slot_valid;
    logic [15:0]             stall_cnt;

    modport master (
        output freeze, flush, id_valid, id_src_reg, id_src_en,
               id_dst_reg, id_dst_en, id_is_load,
        input  fwd_sel, stall, slot_valid, stall_cnt
    );

    modport slave (
        input  freeze, flush, id_valid, id_src_reg, id_src_en,
               id_dst_reg, id_dst_en, id_is_load,
        output fwd_sel, stall, slot_valid, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Purpose: interlock/forwarding controller tracking in-flight destination registers over DEPTH slots.
// Latency: fwd_sel/stall are combinational from slot state and ID inputs; slots advance one per unfrozen clock.
// Backpressure: stall holds IF/ID and injects a bubble; freeze holds all state; flush squashes young slots.
`timescale 1ns/1ps
module hazard_scoreboard #(
    parameter int NUM_REGS      = 16,
    parameter int DEPTH         = 3,
    parameter int NUM_SRC       = 2,
    parameter int LOAD_FWD_SLOT = 1,
    parameter int FLUSH_SLOTS   = 2,
    parameter int ZERO_REG      = 1
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int AW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SELW = $clog2(DEPTH + 1);

    // slot s: 0 is EX (youngest), DEPTH-1 is WB (oldest)
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] ld_q, ld_d;
    logic [AW-1:0]    dst_q [DEPTH];
    logic [AW-1:0]    dst_d [DEPTH];
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC*SELW-1:0] fwd_sel;
    logic                    stall_raw;
    logic                    stall;

    // per-source youngest-match search; a load too young to forward raises the interlock
    always_comb begin
        logic [AW-1:0]   src;
        logic [SELW-1:0] sel_k;
        logic            lu_k;
        fwd_sel   = '0;
        stall_raw = 1'b0;
        src       = '0;
        sel_k     = '0;
        lu_k      = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src   = bus.id_src_reg[k*AW +: AW];
            sel_k = '0;
            lu_k  = 1'b0;
            // walk oldest to youngest so the youngest match is the one left standing
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (vld_q[s] && (dst_q[s] == src)) begin
                    sel_k = SELW'(s + 1);
                    lu_k  = ld_q[s] && (s < LOAD_FWD_SLOT);
                end
            end
            if (!(bus.id_valid && bus.id_src_en[k]) || ((ZERO_REG != 0) && (src == '0))) begin
                sel_k = '0;
                lu_k  = 1'b0;
            end
            fwd_sel[k*SELW +: SELW] = sel_k;
            stall_raw               = stall_raw | lu_k;
        end
        // a taken branch squashes the dependent anyway, so never stall on it
        stall = stall_raw & ~bus.flush;
    end

    // next slot contents: shift towards WB, admit ID (or a bubble when stalling), flush young slots
    always_comb begin
        vld_d       = vld_q;
        ld_d        = ld_q;
        dst_d       = dst_q;
        stall_cnt_d = stall_cnt_q;
        if (!bus.freeze) begin
            for (int s = 1; s < DEPTH; s++) begin
                vld_d[s] = vld_q[s-1];
                ld_d[s]  = ld_q[s-1];
                dst_d[s] = dst_q[s-1];
            end
            vld_d[0] = bus.id_valid & bus.id_dst_en & ~stall;
            ld_d[0]  = bus.id_is_load;
            dst_d[0] = bus.id_dst_reg;
            if (bus.flush) begin
                for (int s = 0; s < FLUSH_SLOTS; s++) begin
                    vld_d[s] = 1'b0;
                    ld_d[s]  = 1'b0;
                    dst_d[s] = '0;
                end
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            ld_q        <= '0;
            stall_cnt_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                dst_q[s] <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            ld_q        <= ld_d;
            dst_q       <= dst_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fwd_sel    = fwd_sel;
    assign bus.stall      = stall;
    assign bus.slot_valid = vld_q;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule
